key_hold_tracker: RTL and testbench
===================================

KEY_HOLD_TRACKER -- requirements
Module: key_hold_tracker

Interface
REQ-001 SHALL have parameter: FIRE_COOLDOWN, 5_000_000, clk cycles between auto-repeat fire pulses while space is held; legal range 2..2^24-1.
REQ-002 SHALL have port: clk  input  1  system clock; all state changes on rising edge.
REQ-003 SHALL have port: reset  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port: code_valid  input  1  one-cycle tick from the PS/2 receiver; code is valid in that cycle.
REQ-005 SHALL have port: code  input  8  raw PS/2 set-2 byte (make, F0 break prefix, E0 extended prefix).
REQ-006 SHALL have port: clear  input  1  synchronous release of all keys (game over or level change).
REQ-007 SHALL have port: held  output  9  key-held bitmask: [0]=A 1C, [1]=D 23, [2]=S 1B, [3]=W 1D, [4]=space 29, [5]=up E0 75, [6]=left E0 6B, [7]=down E0 72, [8]=right E0 74.
REQ-008 SHALL have port: any_held  output  1  OR of held, combinational.
REQ-009 SHALL have port: fire_pulse  output  1  one-cycle registered fire strobe.

Function
REQ-010 SHALL decode with a 4-state FSM: IDLE, BRK, EXT, EXT_BRK; the state advances only in cycles where code_valid=1.
REQ-011 IDLE: F0 -> BRK; E0 -> EXT; plain-map code -> set its held bit, stay IDLE; any other code -> ignore, stay IDLE.
REQ-012 BRK: F0 -> stay BRK; plain-map code -> clear its held bit; any non-F0 code -> IDLE.
REQ-013 EXT: E0 -> stay EXT; F0 -> EXT_BRK; extended-map code -> set its held bit; any other non-E0, non-F0 code -> IDLE, no bit change.
REQ-014 EXT_BRK: extended-map code -> clear its held bit; any code -> IDLE.
REQ-015 Codes 75/6B/72/74 without an E0 prefix (keypad) SHALL NOT affect held[8:5].
REQ-016 Plain-map codes received after E0 SHALL NOT affect held[4:0] (for example, E0 1D does not set W).
REQ-017 held SHALL update on the clk edge that ends the code_valid cycle, giving 1-cycle latency.
REQ-018 A typematic repeat make for an already-held key SHALL leave held unchanged.
REQ-019 A break for a key not held SHALL leave held unchanged.
REQ-020 fire_pulse SHALL be 1 in the first cycle in which held[4] reads 1 after reading 0.
REQ-021 While held[4] stays 1, fire_pulse SHALL repeat every FIRE_COOLDOWN cycles after that first pulse, each pulse exactly one cycle wide.
REQ-022 Repeat space makes SHALL NOT restart or add to the cadence.
REQ-023 fire_pulse SHALL be 0 in every cycle in which held[4] reads 0.
REQ-024 The cooldown counter SHALL clear when held[4] reads 0, so re-pressing space fires immediately.
REQ-025 clear=1 SHALL, at the next edge, zero held, return the FSM to IDLE and zero the counter.
REQ-026 clear SHALL take priority over a simultaneous code_valid, and that code is discarded.
REQ-027 The cooldown counter SHALL be 24 bits and SHALL NOT wrap while held[4]=1.

Reset
REQ-028 reset=1 SHALL asynchronously force state=IDLE, held=0, fire_pulse=0 and cooldown counter=0.
REQ-029 Reset asserted mid-sequence (after F0 or E0) SHALL discard the partial prefix; the first byte after release is decoded from IDLE.
REQ-030 All outputs SHALL be 0 while reset is asserted.

Verification
REQ-031 Bench SHALL drive 1D, then F0 1D, with ticks 10 cycles apart -> held=0x008 one cycle after the first tick; held=0x000 one cycle after the 1D following F0.
REQ-032 Bench SHALL drive E0 75, then 75, then E0 F0 75 -> held[5]=1 after E0 75; keypad 75 leaves held unchanged; held[5]=0 after E0 F0 75.
REQ-033 Bench SHALL run with FIRE_COOLDOWN=8, send 29 at cycle 0, then repeat 29 at cycle 5, then F0 29 at cycle 30 -> fire_pulse at cycles 1, 9, 17, 25 only; none after held[4] clears.
REQ-034 Bench SHALL send 29, F0 29, 29 in quick succession -> two fire pulses, one cycle after each make.
REQ-035 Bench SHALL hold A and right, then pulse clear coincident with a 23 tick -> held=0 next cycle; D is not set; any_held=0.
REQ-036 Bench SHALL send F0, assert reset, then send 1C -> held=0x001; the 1C is treated as a make, not a break.

Source files
------------

// File: rtl/key_hold_tracker.sv
// key_hold_tracker
//   Decodes a stream of raw PS/2 set-2 bytes into a held-key bitmask for the
//   game controls and generates an auto-repeat fire strobe while space is held.
//
// Parameters:
//   FIRE_COOLDOWN  clk cycles between auto-repeat fire pulses (2 .. 2^24-1)
//
// Ports:
//   clk         system clock, rising edge
//   reset       asynchronous, active-high reset
//   code_valid  one-cycle tick, code is valid in that cycle
//   code        raw PS/2 byte (make, F0 break prefix, E0 extended prefix)
//   clear       synchronous release of all keys; wins over code_valid
//   held        [0]=A [1]=D [2]=S [3]=W [4]=space
//               [5]=up [6]=left [7]=down [8]=right (arrows need the E0 prefix)
//   any_held    OR of held
//   fire_pulse  registered one-cycle fire strobe
module key_hold_tracker #(
    parameter int unsigned FIRE_COOLDOWN = 5_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       code_valid,
    input  logic [7:0] code,
    input  logic       clear,
    output logic [8:0] held,
    output logic       any_held,
    output logic       fire_pulse
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BRK     = 2'd1,
        EXT     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    localparam logic [7:0]  CODE_BREAK = 8'hF0;
    localparam logic [7:0]  CODE_EXT   = 8'hE0;
    localparam logic [23:0] COOL_LAST  = 24'(FIRE_COOLDOWN - 32'd1);

    // One-hot held bit for a code that is meaningful without the E0 prefix.
    function automatic logic [8:0] plain_mask(input logic [7:0] c);
        logic [8:0] m;
        case (c)
            8'h1C:   m = 9'h001;
            8'h23:   m = 9'h002;
            8'h1B:   m = 9'h004;
            8'h1D:   m = 9'h008;
            8'h29:   m = 9'h010;
            default: m = 9'h000;
        endcase
        return m;
    endfunction

    // One-hot held bit for a code that is meaningful only after E0.
    function automatic logic [8:0] ext_mask(input logic [7:0] c);
        logic [8:0] m;
        case (c)
            8'h75:   m = 9'h020;
            8'h6B:   m = 9'h040;
            8'h72:   m = 9'h080;
            8'h74:   m = 9'h100;
            default: m = 9'h000;
        endcase
        return m;
    endfunction

    state_t      state_r, state_s;
    logic [8:0]  held_r, held_s;
    logic [23:0] cnt_r, cnt_s;
    logic        fire_r, fire_s;

    // State, key mask, cooldown counter and fire strobe registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r <= IDLE;
            held_r  <= 9'h000;
            cnt_r   <= 24'd0;
            fire_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            held_r  <= held_s;
            cnt_r   <= cnt_s;
            fire_r  <= fire_s;
        end
    end

    // Prefix decoder: next state and next key mask.
    always_comb begin
        state_s = state_r;
        held_s  = held_r;
        if (clear) begin
            state_s = IDLE;
            held_s  = 9'h000;
        end else if (code_valid) begin
            case (state_r)
                IDLE: begin
                    if (code == CODE_BREAK) begin
                        state_s = BRK;
                    end else if (code == CODE_EXT) begin
                        state_s = EXT;
                    end else begin
                        held_s = held_r | plain_mask(code);
                    end
                end
                BRK: begin
                    // Repeated F0 keeps waiting; anything else ends the break.
                    if (code == CODE_BREAK) begin
                        state_s = BRK;
                    end else begin
                        held_s  = held_r & ~plain_mask(code);
                        state_s = IDLE;
                    end
                end
                EXT: begin
                    if (code == CODE_EXT) begin
                        state_s = EXT;
                    end else if (code == CODE_BREAK) begin
                        state_s = EXT_BRK;
                    end else begin
                        held_s  = held_r | ext_mask(code);
                        state_s = IDLE;
                    end
                end
                EXT_BRK: begin
                    held_s  = held_r & ~ext_mask(code);
                    state_s = IDLE;
                end
                default: begin
                    state_s = IDLE;
                end
            endcase
        end else begin
            state_s = state_r;
            held_s  = held_r;
        end
    end

    // Fire cadence: the strobe is computed from the next mask so that it
    // coincides with the first cycle space reads as held. The counter
    // restarts at every pulse, so it never exceeds COOL_LAST and cannot wrap.
    always_comb begin
        cnt_s  = 24'd0;
        fire_s = 1'b0;
        if (!held_s[4]) begin
            cnt_s  = 24'd0;
            fire_s = 1'b0;
        end else if (!held_r[4]) begin
            cnt_s  = 24'd0;
            fire_s = 1'b1;
        end else if (cnt_r == COOL_LAST) begin
            cnt_s  = 24'd0;
            fire_s = 1'b1;
        end else begin
            cnt_s  = cnt_r + 24'd1;
            fire_s = 1'b0;
        end
    end

    assign held       = held_r;
    assign any_held   = |held_r;
    assign fire_pulse = fire_r;

endmodule

// File: tb/tb_key_hold_tracker.sv
module tb_key_hold_tracker;

    localparam int CD = 8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       code_valid = 1'b0;
    logic [7:0] code = 8'h00;
    logic       clear = 1'b0;
    logic [8:0] held;
    logic       any_held;
    logic       fire_pulse;

    int vectors = 0;
    int errors  = 0;

    // Reference model: pending-prefix flags, key mask and fire timing.
    logic [8:0] m_held = 9'h000;
    bit         m_brk = 1'b0;
    bit         m_ext = 1'b0;
    bit         m_fire = 1'b0;
    int         cyc = 0;
    int         rise = 0;

    key_hold_tracker #(.FIRE_COOLDOWN(CD)) dut (
        .clk        (clk),
        .reset      (reset),
        .code_valid (code_valid),
        .code       (code),
        .clear      (clear),
        .held       (held),
        .any_held   (any_held),
        .fire_pulse (fire_pulse)
    );

    always #5 clk = ~clk;

    function automatic int plain_idx(input logic [7:0] b);
        case (b)
            8'h1C: return 0;
            8'h23: return 1;
            8'h1B: return 2;
            8'h1D: return 3;
            8'h29: return 4;
            default: return -1;
        endcase
    endfunction

    function automatic int ext_idx(input logic [7:0] b);
        case (b)
            8'h75: return 5;
            8'h6B: return 6;
            8'h72: return 7;
            8'h74: return 8;
            default: return -1;
        endcase
    endfunction

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply one byte to the model as the keyboard protocol describes.
    task automatic model_byte(input logic [7:0] b);
        int k;
        if (b == 8'hF0) begin
            if (m_ext && m_brk) begin m_ext = 0; m_brk = 0; end
            else m_brk = 1;
        end else if (b == 8'hE0) begin
            if (m_brk) begin m_ext = 0; m_brk = 0; end
            else m_ext = 1;
        end else begin
            k = m_ext ? ext_idx(b) : plain_idx(b);
            if (k >= 0) m_held[k] = !m_brk;
            m_ext = 0;
            m_brk = 0;
        end
    endtask

    // One clock cycle: drive inputs, advance model at the edge, compare after it.
    task automatic step(input logic v, input logic [7:0] c, input logic clr);
        bit old4;
        code_valid = v;
        code = c;
        clear = clr;
        @(posedge clk);
        cyc++;
        old4 = m_held[4];
        if (clr) begin
            m_held = 9'h000; m_brk = 0; m_ext = 0;
        end else if (v) begin
            model_byte(c);
        end
        if (m_held[4]) begin
            if (!old4) rise = cyc;
            m_fire = ((cyc - rise) % CD) == 0;
        end else begin
            m_fire = 0;
        end
        #1;
        check("held", 64'(held), 64'(m_held));
        check("any_held", 64'(any_held), 64'(|m_held));
        check("fire_pulse", 64'(fire_pulse), 64'(m_fire));
        code_valid = 1'b0;
        clear = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 8'h00, 1'b0);
    endtask

    initial begin
        logic [63:0] pulses;
        logic [63:0] exp_pulses;
        logic [7:0]  pool [12];
        int          npulse;

        pool = '{8'hF0, 8'hE0, 8'h1C, 8'h23, 8'h1B, 8'h1D, 8'h29,
                 8'h75, 8'h6B, 8'h72, 8'h74, 8'h00};

        // Outputs during power-on reset.
        #12;
        check("reset_held", 64'(held), 64'h0);
        check("reset_any", 64'(any_held), 64'h0);
        check("reset_fire", 64'(fire_pulse), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        idle(2);

        // W make then break, ticks 10 cycles apart.
        step(1'b1, 8'h1D, 1'b0);
        check("w_make", 64'(held), 64'h008);
        idle(9);
        step(1'b1, 8'hF0, 1'b0);
        idle(9);
        step(1'b1, 8'h1D, 1'b0);
        check("w_break", 64'(held), 64'h000);

        // Extended up, keypad 8 ignored, extended up release.
        step(1'b1, 8'hE0, 1'b0);
        step(1'b1, 8'h75, 1'b0);
        check("up_make", 64'(held), 64'h020);
        step(1'b1, 8'h75, 1'b0);
        check("keypad_75", 64'(held), 64'h020);
        step(1'b1, 8'hE0, 1'b0);
        step(1'b1, 8'hF0, 1'b0);
        step(1'b1, 8'h75, 1'b0);
        check("up_break", 64'(held), 64'h000);

        // E0 1D must not press W.
        step(1'b1, 8'hE0, 1'b0);
        step(1'b1, 8'h1D, 1'b0);
        check("e0_1d", 64'(held), 64'h000);

        // Fire cadence: make at cycle 0, repeat at 5, break bytes at 30/31.
        pulses = 64'h0;
        for (int k = 0; k < 45; k++) begin
            step((k == 0 || k == 5 || k == 30 || k == 31),
                 (k == 30) ? 8'hF0 : 8'h29, 1'b0);
            if (fire_pulse) pulses[k + 1] = 1'b1;
        end
        exp_pulses = (64'h1 << 1) | (64'h1 << 9) | (64'h1 << 17) | (64'h1 << 25);
        check("fire_cadence", pulses, exp_pulses);

        // Make, break, make in quick succession: two pulses.
        npulse = 0;
        for (int k = 0; k < 8; k++) begin
            step(k < 4, (k == 1) ? 8'hF0 : 8'h29, 1'b0);
            if (fire_pulse) npulse++;
        end
        check("refire_count", 64'(npulse), 64'd2);
        step(1'b1, 8'hF0, 1'b0);
        step(1'b1, 8'h29, 1'b0);

        // Hold A and right, then clear together with a D make.
        step(1'b1, 8'h1C, 1'b0);
        step(1'b1, 8'hE0, 1'b0);
        step(1'b1, 8'h74, 1'b0);
        check("a_right", 64'(held), 64'h101);
        step(1'b1, 8'h23, 1'b1);
        check("clear_held", 64'(held), 64'h000);
        check("clear_any", 64'(any_held), 64'h0);

        // Reset after a dangling F0: next 1C is a make.
        step(1'b1, 8'h1D, 1'b0);
        step(1'b1, 8'hF0, 1'b0);
        #2;
        reset = 1'b1;
        #1;
        m_held = 9'h000; m_brk = 0; m_ext = 0; m_fire = 0;
        check("async_reset_held", 64'(held), 64'h000);
        check("async_reset_any", 64'(any_held), 64'h0);
        @(negedge clk);
        reset = 1'b0;
        step(1'b1, 8'h1C, 1'b0);
        check("post_reset_make", 64'(held), 64'h001);
        step(1'b0, 8'h00, 1'b1);

        // Randomized byte stream against the model.
        for (int i = 0; i < 600; i++) begin
            logic       v;
            logic       clr;
            logic [7:0] b;
            int         idx;
            clr = ($urandom_range(0, 99) < 2);
            v   = ($urandom_range(0, 99) < 60);
            idx = $urandom_range(0, 11);
            b   = (idx == 11) ? 8'($urandom_range(0, 255)) : pool[idx];
            step(v, b, clr);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
